ram_seq_ctrl: RTL and testbench



---
 rtl/ram_seq_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_ram_seq_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_seq_ctrl.sv
// Command/fill sequencer driving a single-port RAM (addr/din/write/select).
// Optional macro RAM_SEQ_CTRL_STATS_EN adds saturating wr_count/rd_count outputs.
module ram_seq_ctrl #(
    parameter int unsigned AW        = 4,
    parameter int unsigned DW        = 4,
    parameter int unsigned FILL_STEP = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    input  logic          fill_start,
    output logic          busy,
    output logic          fill_done,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_write,
    output logic          ram_select,
    input  logic [DW-1:0] ram_dout
`ifdef RAM_SEQ_CTRL_STATS_EN
    ,
    output logic [15:0]   wr_count,
    output logic [15:0]   rd_count
`endif
);

    typedef enum logic [2:0] {IDLE, WR, RD, RD_CAP, RSP, FILL} state_t;

    state_t        state_q, state_d;
    logic [AW:0]   fill_cnt_q, fill_cnt_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic          busy_q, busy_d;
    logic          fill_done_q, fill_done_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_din_q, ram_din_d;
    logic          ram_write_q, ram_write_d;
    logic          ram_select_q, ram_select_d;

    function automatic logic [DW-1:0] fill_pat(input logic [AW-1:0] k);
        return DW'(32'(k) * FILL_STEP);
    endfunction

    // Outputs are registered, so each branch sets the values for the state being entered.
    always_comb begin
        state_d      = state_q;
        fill_cnt_d   = fill_cnt_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_rdata_d  = rsp_rdata_q;
        fill_done_d  = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_din_d    = ram_din_q;
        ram_write_d  = 1'b0;
        ram_select_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (fill_start) begin
                    state_d      = FILL;
                    fill_cnt_d   = (AW+1)'(1);
                    ram_addr_d   = '0;
                    ram_din_d    = fill_pat('0);
                    ram_write_d  = 1'b1;
                    ram_select_d = 1'b1;
                end else if (cmd_valid && cmd_ready_q) begin
                    ram_addr_d   = cmd_addr;
                    ram_select_d = 1'b1;
                    if (cmd_write) begin
                        state_d     = WR;
                        ram_din_d   = cmd_wdata;
                        ram_write_d = 1'b1;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            WR:     state_d = IDLE;
            RD:     state_d = RD_CAP;
            RD_CAP: begin
                rsp_rdata_d = ram_dout;
                rsp_valid_d = 1'b1;
                state_d     = RSP;
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            FILL: begin
                // Counter is one bit wider so the top bit flags "all locations written".
                if (fill_cnt_q[AW]) begin
                    state_d     = IDLE;
                    fill_done_d = 1'b1;
                end else begin
                    ram_addr_d   = fill_cnt_q[AW-1:0];
                    ram_din_d    = fill_pat(fill_cnt_q[AW-1:0]);
                    ram_write_d  = 1'b1;
                    ram_select_d = 1'b1;
                    fill_cnt_d   = fill_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fill_cnt_q   <= '0;
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            busy_q       <= 1'b0;
            fill_done_q  <= 1'b0;
            ram_addr_q   <= '0;
            ram_din_q    <= '0;
            ram_write_q  <= 1'b0;
            ram_select_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_cnt_q   <= fill_cnt_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            busy_q       <= busy_d;
            fill_done_q  <= fill_done_d;
            ram_addr_q   <= ram_addr_d;
            ram_din_q    <= ram_din_d;
            ram_write_q  <= ram_write_d;
            ram_select_q <= ram_select_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign busy       = busy_q;
    assign fill_done  = fill_done_q;
    assign ram_addr   = ram_addr_q;
    assign ram_din    = ram_din_q;
    assign ram_write  = ram_write_q;
    assign ram_select = ram_select_q;

`ifdef RAM_SEQ_CTRL_STATS_EN
    logic [15:0] wr_count_q, wr_count_d;
    logic [15:0] rd_count_q, rd_count_d;

    // A registered write strobe marks exactly one WR cycle or one fill write.
    always_comb begin
        wr_count_d = wr_count_q;
        rd_count_d = rd_count_q;
        if (ram_write_q && (wr_count_q != 16'hFFFF))
            wr_count_d = wr_count_q + 16'd1;
        if ((state_q == RSP) && rsp_ready && (rd_count_q != 16'hFFFF))
            rd_count_d = rd_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_count_q <= '0;
            rd_count_q <= '0;
        end else begin
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
        end
    end

    assign wr_count = wr_count_q;
    assign rd_count = rd_count_q;
`endif

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Directed self-checking bench for ram_seq_ctrl with a behavioural 16x4 synchronous RAM.
module tb_ram_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [3:0] cmd_addr;
    logic [3:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_rdata;
    logic       fill_start;
    logic       busy;
    logic       fill_done;
    logic [3:0] ram_addr;
    logic [3:0] ram_din;
    logic       ram_write;
    logic       ram_select;
    logic [3:0] ram_dout;

    logic [3:0] mem [16];

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    ram_seq_ctrl #(.AW(4), .DW(4), .FILL_STEP(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .fill_start(fill_start),
        .busy      (busy),
        .fill_done (fill_done),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_write (ram_write),
        .ram_select(ram_select),
        .ram_dout  (ram_dout)
    );

    always @(posedge clk) begin
        if (ram_select) begin
            if (ram_write) mem[ram_addr] <= ram_din;
            else           ram_dout      <= mem[ram_addr];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input logic [3:0] a, input logic [3:0] exp);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; rsp_ready = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("rd_strobe_sel", 16'(ram_select), 16'd1);
        chk("rd_strobe_wr", 16'(ram_write), 16'd0);
        chk("rd_addr", 16'(ram_addr), 16'(a));
        step();
        chk("rd_valid_early", 16'(rsp_valid), 16'd0);
        step();
        chk("rd_valid", 16'(rsp_valid), 16'd1);
        chk("rd_data", 16'(rsp_rdata), 16'(exp));
        step();
        chk("rd_valid_clear", 16'(rsp_valid), 16'd0);
        chk("rd_ready_back", 16'(cmd_ready), 16'd1);
    endtask

    logic [3:0] fill_exp [9];

    initial begin
        fill_exp = '{4'd0, 4'd2, 4'd4, 4'd6, 4'd8, 4'd10, 4'd12, 4'd14, 4'd0};
        for (int i = 0; i < 16; i++) mem[i] = 4'h0;
        ram_dout = 4'h0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 4'h0;
        cmd_wdata = 4'h0; rsp_ready = 1'b0; fill_start = 1'b0;

        // 1: reset
        step();
        chk("rst_cmd_ready", 16'(cmd_ready), 16'd0);
        chk("rst_sel", 16'(ram_select), 16'd0);
        chk("rst_wr", 16'(ram_write), 16'd0);
        chk("rst_rsp_valid", 16'(rsp_valid), 16'd0);
        chk("rst_rdata", 16'(rsp_rdata), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_fill_done", 16'(fill_done), 16'd0);
        chk("rst_addr", 16'(ram_addr), 16'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", 16'(cmd_ready), 16'd1);
        chk("post_rst_busy", 16'(busy), 16'd0);

        // 2: write 3<=A then read back
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd3; cmd_wdata = 4'hA;
        step();
        cmd_valid = 1'b0;
        chk("wr_write", 16'(ram_write), 16'd1);
        chk("wr_sel", 16'(ram_select), 16'd1);
        chk("wr_addr", 16'(ram_addr), 16'd3);
        chk("wr_din", 16'(ram_din), 16'hA);
        chk("wr_busy", 16'(busy), 16'd1);
        chk("wr_ready", 16'(cmd_ready), 16'd0);
        step();
        chk("wr_done_write", 16'(ram_write), 16'd0);
        chk("wr_done_sel", 16'(ram_select), 16'd0);
        chk("wr_done_ready", 16'(cmd_ready), 16'd1);
        do_read(4'd3, 4'hA);

        // 3: fill then read 0..8
        fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("fill_write", 16'(ram_write), 16'd1);
            chk("fill_addr", 16'(ram_addr), 16'(k));
            chk("fill_din", 16'(ram_din), 16'((k * 2) % 16));
            chk("fill_done_early", 16'(fill_done), 16'd0);
            chk("fill_busy", 16'(busy), 16'd1);
            step();
        end
        chk("fill_done", 16'(fill_done), 16'd1);
        chk("fill_end_write", 16'(ram_write), 16'd0);
        chk("fill_end_busy", 16'(busy), 16'd0);
        step();
        chk("fill_done_pulse", 16'(fill_done), 16'd0);
        for (int a = 0; a < 9; a++) do_read(4'(a), fill_exp[a]);

        // 4: read 5 with response back-pressure, pending write held during RSP
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'd5; rsp_ready = 1'b0;
        step();
        cmd_write = 1'b1; cmd_addr = 4'd9; cmd_wdata = 4'hF;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 16'(rsp_valid), 16'd1);
            chk("hold_data", 16'(rsp_rdata), 16'hA);
            chk("hold_ready", 16'(cmd_ready), 16'd0);
            chk("hold_sel", 16'(ram_select), 16'd0);
            step();
        end
        rsp_ready = 1'b1;
        chk("hs_valid", 16'(rsp_valid), 16'd1);
        step();
        chk("hs_clear", 16'(rsp_valid), 16'd0);
        chk("hs_ready", 16'(cmd_ready), 16'd1);
        step();
        cmd_valid = 1'b0;
        chk("pend_write", 16'(ram_write), 16'd1);
        chk("pend_addr", 16'(ram_addr), 16'd9);
        chk("pend_din", 16'(ram_din), 16'hF);
        step();

        // 5: fill beats simultaneous command; command lands after fill_done
        fill_start = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd2; cmd_wdata = 4'd7;
        step();
        fill_start = 1'b0;
        chk("prio_fill_addr", 16'(ram_addr), 16'd0);
        chk("prio_fill_din", 16'(ram_din), 16'd0);
        chk("prio_busy", 16'(busy), 16'd1);
        for (int k = 1; k < 16; k++) step();
        chk("prio_last_addr", 16'(ram_addr), 16'd15);
        chk("prio_last_din", 16'(ram_din), 16'd14);
        step();
        chk("prio_done", 16'(fill_done), 16'd1);
        chk("prio_ready", 16'(cmd_ready), 16'd1);
        step();
        cmd_valid = 1'b0;
        chk("prio_cmd_write", 16'(ram_write), 16'd1);
        chk("prio_cmd_addr", 16'(ram_addr), 16'd2);
        chk("prio_cmd_din", 16'(ram_din), 16'd7);
        step();
        do_read(4'd2, 4'd7);

        // 6: reset mid-fill at k=7
        fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        for (int k = 1; k < 8; k++) step();
        chk("mid_addr", 16'(ram_addr), 16'd7);
        rst_n = 1'b0;
        step();
        chk("mid_rst_write", 16'(ram_write), 16'd0);
        chk("mid_rst_sel", 16'(ram_select), 16'd0);
        chk("mid_rst_busy", 16'(busy), 16'd0);
        chk("mid_rst_done", 16'(fill_done), 16'd0);
        rst_n = 1'b1;
        step();
        chk("mid_after_done", 16'(fill_done), 16'd0);
        chk("mid_after_ready", 16'(cmd_ready), 16'd1);
        chk("mid_after_write", 16'(ram_write), 16'd0);
        step();
        chk("mid_after_done2", 16'(fill_done), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
